// File: rtl/csa_add_scheduler.sv
// Two-requester round-robin scheduler around a shared 4-bit carry-select adder slice.
// Each WIDTH-bit add runs LSB chunk first, one chunk per cycle, with a registered inter-chunk carry.
module csa_add_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int NCHUNK = WIDTH / 4;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            ptr_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic            carry_r;
    logic [CW-1:0]   cnt_r;
    logic            grant0_s;
    logic            grant1_s;
    logic            accept_s;
    logic            last_s;
    logic [4:0]      chunk_s;

    // Both candidate sums are formed unconditionally; the incoming carry only selects between them.
    function automatic logic [4:0] csa_chunk(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] s0;
        logic [4:0] s1;
        s0 = {1'b0, a} + {1'b0, b};
        s1 = s0 + 5'd1;
        return cin ? s1 : s0;
    endfunction

    assign accept_s   = grant0_s | grant1_s;
    assign last_s     = (cnt_r == CW'(NCHUNK - 1));
    assign chunk_s    = csa_chunk(a_r[{cnt_r, 2'b00} +: 4], b_r[{cnt_r, 2'b00} +: 4], carry_r);
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = ADD;
                else          state_nxt_s = IDLE;
            end
            ADD: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = ADD;
            end
            DONE: begin
                if (res_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant outputs: only in IDLE; a sole requester wins, a tie goes to the pointer side.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            grant0_s = req0_valid & (~req1_valid | ~ptr_r);
            grant1_s = req1_valid & (~req0_valid |  ptr_r);
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand capture, chunk-serial datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ptr_r   <= grant0_s;
                        a_r     <= grant1_s ? req1_a   : req0_a;
                        b_r     <= grant1_s ? req1_b   : req0_b;
                        carry_r <= grant1_s ? req1_cin : req0_cin;
                        res_id  <= grant1_s;
                        cnt_r   <= '0;
                    end
                end
                ADD: begin
                    res_sum[{cnt_r, 2'b00} +: 4] <= chunk_s[3:0];
                    carry_r                      <= chunk_s[4];
                    if (last_s) begin
                        res_cout  <= chunk_s[4];
                        res_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: res_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_add_scheduler.sv
// Scoreboard bench for csa_add_scheduler at WIDTH 4, 16 and 32: directed scenarios then random traffic,
// with a cycle-level reference of arbitration, latency and A+B+cin arithmetic.
module tb_csa_add_scheduler;

    logic clk;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int w, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL w%0d %s: actual=%0h required=%0h", w, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W    = (g == 0) ? 4 : ((g == 1) ? 16 : 32);
        localparam int NC   = W / 4;
        localparam int NOPS = (g == 1) ? 600 : 700;

        logic         rst, v0, r0, c0, v1, r1, c1, rv, rr, rc, rid;
        logic [W-1:0] a0, b0, a1, b1, rs;
        logic [W+1:0] q[$];

        csa_add_scheduler #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
            .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
            .res_valid(rv), .res_ready(rr), .res_sum(rs), .res_cout(rc), .res_id(rid)
        );

        function automatic logic [W-1:0] rnd();
            return W'({$urandom(), $urandom()});
        endfunction

        task automatic cyc();
            @(posedge clk);
            #1;
        endtask

        task automatic reset_dut();
            rst = 1'b1;
            v0  = 1'b0;
            v1  = 1'b0;
            rr  = 1'b1;
            repeat (2) cyc();
            rst = 1'b0;
        endtask

        task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
            logic acc;
            logic ok;
            ok = 1'b0;
            if (id) begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
            else    begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                acc = id ? (v1 && r1) : (v0 && r0);
                cyc();
                ok = acc;
            end
            if (id) v1 = 1'b0;
            else    v0 = 1'b0;
            chk(W, "accept_bound", 64'(ok), 64'd1);
        endtask

        task automatic wait_result();
            logic got;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = rv && rr;
                cyc();
            end
            chk(W, "result_bound", 64'(got), 64'd1);
        endtask

        // Reference model: arbitration, latency and expected results, evaluated mid-cycle.
        initial begin : mon
            bit           m_busy, m_add, ptr;
            int           k;
            logic         e0, e1;
            logic [W:0]   full;
            m_busy = 1'b0; m_add = 1'b0; ptr = 1'b0; k = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    m_busy = 1'b0; m_add = 1'b0; ptr = 1'b0; k = 0;
                end else begin
                    chk(W, "res_valid_timing", 64'(rv), 64'(m_busy && !m_add));
                    if (rv) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL w%0d orphan_result: res_valid=1 with no outstanding add", W);
                        end else begin
                            chk(W, "result", 64'({rid, rc, rs}), 64'(q[0]));
                            if (rr) void'(q.pop_front());
                        end
                    end
                    e0 = !m_busy && v0 && (!v1 || !ptr);
                    e1 = !m_busy && v1 && (!v0 ||  ptr);
                    chk(W, "req0_ready", 64'(r0), 64'(e0));
                    chk(W, "req1_ready", 64'(r1), 64'(e1));
                    if (m_add) begin
                        if (k == NC - 1) m_add = 1'b0;
                        else             k++;
                    end else if (m_busy) begin
                        if (rr) m_busy = 1'b0;
                    end else if (e0 || e1) begin
                        full = {1'b0, e1 ? a1 : a0} + {1'b0, e1 ? b1 : b0};
                        full = full + {{W{1'b0}}, e1 ? c1 : c0};
                        q.push_back({e1, full});
                        m_busy = 1'b1; m_add = 1'b1; k = 0;
                        ptr = e0;
                    end
                end
            end
        end

        // Stimulus: directed scenarios followed by random traffic with stalls.
        initial begin : drv
            logic       acc0, acc1;
            logic [3:0] order;
            int         n;
            rst = 1'b1; rr = 1'b1;
            v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0;
            v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
            repeat (2) cyc();
            chk(W, "rst_valid", 64'(rv),  64'd0);
            chk(W, "rst_sum",   64'(rs),  64'd0);
            chk(W, "rst_cout",  64'(rc),  64'd0);
            chk(W, "rst_id",    64'(rid), 64'd0);
            rst = 1'b0;

            issue(1'b0, '1, W'(1), 1'b0);
            wait_result();
            issue(1'b1, {1'b0, {(W-1){1'b1}}}, '0, 1'b1);
            wait_result();

            reset_dut();
            v0 = 1'b1; a0 = rnd(); b0 = rnd(); c0 = 1'($urandom());
            v1 = 1'b1; a1 = rnd(); b1 = rnd(); c1 = 1'($urandom());
            order = '0;
            n = 0;
            for (int i = 0; i < 200 && n < 4; i++) begin
                @(negedge clk);
                acc0 = v0 && r0;
                acc1 = v1 && r1;
                chk(W, "t3_one_ready", 64'(r0 && r1), 64'd0);
                cyc();
                if (acc0 || acc1) begin
                    order = {order[2:0], acc1};
                    n++;
                end
                if (acc0) begin a0 = rnd(); b0 = rnd(); c0 = 1'($urandom()); end
                if (acc1) begin a1 = rnd(); b1 = rnd(); c1 = 1'($urandom()); end
            end
            v0 = 1'b0;
            v1 = 1'b0;
            chk(W, "t3_grant_order", 64'(order), 64'h5);
            wait_result();

            issue(1'b0, rnd(), rnd(), 1'($urandom()));
            rr = 1'b0;
            n = 0;
            for (int i = 0; i < 100 && n == 0; i++) begin
                @(negedge clk);
                if (rv) n = 1;
                else    cyc();
            end
            chk(W, "t4_valid_bound", 64'(n), 64'd1);
            repeat (3) cyc();
            rr = 1'b1;
            wait_result();

            reset_dut();
            issue(1'b1, rnd() | W'(1), rnd(), 1'b1);
            repeat ((NC > 2) ? 2 : 0) cyc();
            rst = 1'b1;
            #1;
            chk(W, "t5_valid", 64'(rv),  64'd0);
            chk(W, "t5_sum",   64'(rs),  64'd0);
            chk(W, "t5_cout",  64'(rc),  64'd0);
            chk(W, "t5_id",    64'(rid), 64'd0);
            repeat (2) cyc();
            rst = 1'b0;
            v0 = 1'b1; a0 = rnd(); b0 = rnd(); c0 = 1'($urandom());
            v1 = 1'b1; a1 = rnd(); b1 = rnd(); c1 = 1'($urandom());
            @(negedge clk);
            chk(W, "t5_ready0", 64'(r0), 64'd1);
            chk(W, "t5_ready1", 64'(r1), 64'd0);
            cyc();
            v0 = 1'b0;
            v1 = 1'b0;
            wait_result();

            n = 0;
            for (int i = 0; i < NOPS * 40 && n < NOPS; i++) begin
                @(negedge clk);
                acc0 = v0 && r0;
                acc1 = v1 && r1;
                cyc();
                n += int'(acc0) + int'(acc1);
                rr = ($urandom_range(0, 3) != 0);
                if (acc0 || !v0) begin
                    v0 = ($urandom_range(0, 1) == 1);
                    a0 = rnd(); b0 = rnd(); c0 = 1'($urandom());
                end else if ($urandom_range(0, 7) == 0) begin
                    v0 = 1'b0;
                end
                if (acc1 || !v1) begin
                    v1 = ($urandom_range(0, 1) == 1);
                    a1 = rnd(); b1 = rnd(); c1 = 1'($urandom());
                end else if ($urandom_range(0, 7) == 0) begin
                    v1 = 1'b0;
                end
            end
            chk(W, "t6_op_count", 64'(n >= NOPS), 64'd1);
            v0 = 1'b0;
            v1 = 1'b0;
            rr = 1'b1;
            repeat (NC + 4) cyc();
            chk(W, "t6_drained", 64'(q.size()), 64'd0);
            done_cnt++;
        end
    end

    initial begin : summary
        int t;
        for (t = 0; t < 80000 && done_cnt < 3; t++) @(posedge clk);
        checks++;
        if (done_cnt < 3) begin
            errors++;
            $display("FAIL run_bound: finished instances=%0d required=3", done_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
